// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared grant-state and owner-tag encodings plus default geometry for the memory arbiter.
package mem_arbiter_pkg;
  localparam int DEF_MEM_LAT = 4;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DFILL = 2'd2, IFILL = 2'd3} grant_e;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DC = 2'd1, TAG_IC = 2'd2} owner_tag_e;
  // Stores beat D fills, which beat I fills.
  function automatic grant_e idle_pick(input logic wr, input logic dfill, input logic ifill);
    return wr ? WRITE : dfill ? DFILL : ifill ? IFILL : IDLE;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side requests, memory port and fill-return signals of the memory arbiter.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              icache_fill_req;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_fill_req;
  logic [ADDR_W-1:0] dcache_addr;
  logic              dcache_wr_req;
  logic [ADDR_W-1:0] dcache_wr_addr;
  logic [DATA_W-1:0] dcache_wr_data;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_out;
  logic              icache_data_valid;
  logic              dcache_data_valid;
  logic [DATA_W-1:0] fill_data;
  logic              dcache_wr_stall;
  logic              icache_wait;
  modport slave (
    input  icache_fill_req, icache_addr, dcache_fill_req, dcache_addr,
    input  dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_in, mem_data_valid,
    output mem_addr, mem_enable, mem_wr, mem_data_out,
    output icache_data_valid, dcache_data_valid, fill_data, dcache_wr_stall, icache_wait
  );
  modport master (
    output icache_fill_req, icache_addr, dcache_fill_req, dcache_addr,
    output dcache_wr_req, dcache_wr_addr, dcache_wr_data, mem_data_in, mem_data_valid,
    input  mem_addr, mem_enable, mem_wr, mem_data_out,
    input  icache_data_valid, dcache_data_valid, fill_data, dcache_wr_stall, icache_wait
  );
endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// arb_tag_pipe: fixed-depth owner-tag delay line matching memory read latency, built from reset flops.
module arb_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_o <= '0;
    else q_o <= d_i;
endmodule

module arb_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tag_i,
  output logic [1:0] tag_o
);
  logic [DEPTH:0][1:0] stage;
  assign stage[0] = tag_i;
  assign tag_o = stage[DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    arb_dff #(.W(2)) u_dff (.clk(clk), .rst(rst), .d_i(stage[g]), .q_o(stage[g+1]));
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single pipelined memory to stores, D fills or I fills and routes read returns
// back to the requester that issued them using a latency-matched owner-tag pipe.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  grant_e            grant_q, grant_d, pick;
  logic [1:0]        push_tag, head_tag;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_data;
  always_comb begin
    pick = idle_pick(bus.dcache_wr_req, bus.dcache_fill_req, bus.icache_fill_req);
    // A fill owner keeps the grant until its request drops; that release cycle issues nothing.
    grant_d = !rst ? IDLE
            : grant_q == DFILL ? (bus.dcache_fill_req ? DFILL : IDLE)
            : grant_q == IFILL ? (bus.icache_fill_req ? IFILL : IDLE)
            : pick;
    rd_addr = grant_d == IFILL ? bus.icache_addr : bus.dcache_addr;
    wr_data = grant_d == WRITE ? bus.dcache_wr_data : {DATA_W{1'b0}};
    push_tag = grant_d == DFILL ? TAG_DC : grant_d == IFILL ? TAG_IC : TAG_NONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) grant_q <= IDLE;
    else grant_q <= grant_d;
  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tags (
    .clk  (clk),
    .rst  (rst),
    .tag_i(push_tag),
    .tag_o(head_tag)
  );
  assign bus.mem_enable = grant_d != IDLE;
  assign bus.mem_wr = grant_d == WRITE;
  assign bus.mem_addr = grant_d == WRITE ? bus.dcache_wr_addr : grant_d == IDLE ? {ADDR_W{1'b0}} : rd_addr;
  assign bus.mem_data_out = wr_data;
  assign bus.fill_data = bus.mem_data_in;
  // Returns tagged for an owner that has already released are dropped here.
  assign bus.dcache_data_valid = bus.mem_data_valid & (head_tag == TAG_DC) & (grant_q == DFILL);
  assign bus.icache_data_valid = bus.mem_data_valid & (head_tag == TAG_IC) & (grant_q == IFILL);
  assign bus.dcache_wr_stall = rst & bus.dcache_wr_req & (grant_d != WRITE);
  assign bus.icache_wait = rst & bus.icache_fill_req & (grant_q != IFILL) & (grant_d != IFILL);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench; a 4-cycle memory model answers reads, a monitor pops
// expected memory issues and fill returns whenever the arbiter presents them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} mem_t;
  typedef struct packed {logic ic; logic [15:0] data;} ret_t;
  mem_t exp_mem[$];
  ret_t exp_ret[$];
  mem_t mm;
  ret_t rr;
  logic [3:0] rv = '0;
  logic [3:0][15:0] ra = '0;
  logic inj = 1'b0;
  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction
  always @(posedge clk) begin
    rv <= {rv[2:0], bus.mem_enable & ~bus.mem_wr};
    ra <= {ra[2:0], bus.mem_addr};
  end
  assign bus.mem_data_valid = rv[3] | inj;
  assign bus.mem_data_in = mdata(ra[3]);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_enable) begin
      if (exp_mem.size() == 0) chk("mem_unexpected", {31'b0, bus.mem_enable}, 32'd0);
      else begin
        mm = exp_mem.pop_front();
        chk("mem_wr", {31'b0, bus.mem_wr}, {31'b0, mm.wr});
        chk("mem_addr", {16'b0, bus.mem_addr}, {16'b0, mm.addr});
        if (mm.wr) chk("mem_data_out", {16'b0, bus.mem_data_out}, {16'b0, mm.data});
      end
    end
    if (bus.icache_data_valid | bus.dcache_data_valid) begin
      if (exp_ret.size() == 0) chk("ret_unexpected", {30'b0, bus.icache_data_valid, bus.dcache_data_valid}, 32'd0);
      else begin
        rr = exp_ret.pop_front();
        chk("ret_owner", {30'b0, bus.icache_data_valid, bus.dcache_data_valid}, rr.ic ? 32'd2 : 32'd1);
        chk("ret_data", {16'b0, bus.fill_data}, {16'b0, rr.data});
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic rd(input logic [15:0] a);
    exp_mem.push_back('{wr: 1'b0, addr: a, data: 16'h0});
  endtask
  task automatic ret(input logic ic, input logic [15:0] a);
    exp_ret.push_back('{ic: ic, data: mdata(a)});
  endtask
  task automatic quiet;
    bus.icache_fill_req = 0; bus.dcache_fill_req = 0; bus.dcache_wr_req = 0;
  endtask
  initial begin
    logic [15:0] a;
    quiet();
    bus.icache_addr = 0; bus.dcache_addr = 0; bus.dcache_wr_addr = 0; bus.dcache_wr_data = 0;
    // reset held with requests high: everything gated off
    repeat (2) tick();
    bus.icache_fill_req = 1; bus.dcache_wr_req = 1;
    settle();
    chk("rst_mem_enable", {31'b0, bus.mem_enable}, 0);
    chk("rst_stall", {31'b0, bus.dcache_wr_stall}, 0);
    chk("rst_icache_wait", {31'b0, bus.icache_wait}, 0);
    chk("rst_valids", {30'b0, bus.icache_data_valid, bus.dcache_data_valid}, 0);
    quiet();
    tick();
    rst = 1;
    for (int c = 0; c < 10; c++) begin
      tick(); settle();
      chk("idle_mem_enable", {31'b0, bus.mem_enable}, 0);
      chk("idle_valids", {30'b0, bus.icache_data_valid, bus.dcache_data_valid}, 0);
    end
    // D fill at 0x1230: 8 words plus 3 trailing reads, release on cycle 11
    for (int k = 0; k < 15; k++) begin
      tick();
      a = 16'h1230 + 16'(2 * k);
      bus.dcache_fill_req = k < 11; bus.dcache_addr = a;
      if (k < 11) rd(a);
      if (k < 8) ret(1'b0, a);
      settle();
      if (k == 0) chk("d_grant_zero_lat", {31'b0, bus.mem_enable}, 1);
      if (k == 11) chk("d_last_word", {31'b0, bus.dcache_data_valid}, 1);
      if (k >= 12) begin
        chk("d_trail_arrives", {31'b0, bus.mem_data_valid}, 1);
        chk("d_trail_dropped", {31'b0, bus.dcache_data_valid}, 0);
      end
    end
    repeat (3) tick();
    // store to 0x0040 during an I fill stalls until release, then one write cycle
    for (int c = 0; c < 12; c++) begin
      tick();
      a = 16'h2000 + 16'(2 * c);
      bus.icache_fill_req = c < 6; bus.icache_addr = a;
      if (c < 6) rd(a);
      if (c < 3) ret(1'b1, a);
      bus.dcache_wr_req = c >= 2 && c <= 7; bus.dcache_wr_addr = 16'h0040; bus.dcache_wr_data = 16'hBEEF;
      if (c == 7) exp_mem.push_back('{wr: 1'b1, addr: 16'h0040, data: 16'hBEEF});
      settle();
      if (c >= 2 && c <= 6) chk("st_stall", {31'b0, bus.dcache_wr_stall}, 1);
      if (c == 7) begin
        chk("st_accept_stall", {31'b0, bus.dcache_wr_stall}, 0);
        chk("st_accept_wr", {31'b0, bus.mem_wr}, 1);
      end
    end
    quiet();
    repeat (3) tick();
    // both fills rise together: D first, I granted the cycle after D releases
    for (int c = 0; c < 16; c++) begin
      tick();
      bus.dcache_fill_req = c < 4; bus.dcache_addr = 16'h3000 + 16'(2 * c);
      bus.icache_fill_req = c < 11;
      bus.icache_addr = c >= 5 ? 16'h4000 + 16'(2 * (c - 5)) : 16'h4000;
      if (c < 4) rd(bus.dcache_addr);
      if (c == 0) ret(1'b0, bus.dcache_addr);
      if (c >= 5 && c <= 10) rd(bus.icache_addr);
      if (c >= 5 && c <= 7) ret(1'b1, bus.icache_addr);
      settle();
      if (c <= 4) chk("both_icache_wait", {31'b0, bus.icache_wait}, 1);
      if (c == 5) chk("both_i_granted", {31'b0, bus.icache_wait}, 0);
      if (c >= 5 && c <= 7) chk("both_no_ic_on_d_ret", {30'b0, bus.mem_data_valid, bus.icache_data_valid}, 2);
    end
    quiet();
    repeat (3) tick();
    // handover D to I with D reads still in flight
    for (int c = 0; c < 18; c++) begin
      tick();
      bus.dcache_fill_req = c < 6; bus.dcache_addr = 16'h5000 + 16'(2 * c);
      bus.icache_fill_req = c >= 6 && c < 13;
      bus.icache_addr = c >= 7 ? 16'h6000 + 16'(2 * (c - 7)) : 16'h6000;
      if (c < 6) rd(bus.dcache_addr);
      if (c < 3) ret(1'b0, bus.dcache_addr);
      if (c >= 7 && c <= 12) rd(bus.icache_addr);
      if (c >= 7 && c <= 9) ret(1'b1, bus.icache_addr);
      settle();
      if (c == 6) chk("ho_wait_release", {31'b0, bus.icache_wait}, 1);
      if (c == 7) chk("ho_i_granted", {31'b0, bus.icache_wait}, 0);
      if (c >= 7 && c <= 9) chk("ho_d_dropped", {30'b0, bus.mem_data_valid, bus.dcache_data_valid}, 2);
      if (c == 10) chk("ho_ic_not_early", {31'b0, bus.icache_data_valid}, 0);
      if (c == 11) chk("ho_ic_first", {31'b0, bus.icache_data_valid}, 1);
    end
    quiet();
    repeat (6) tick();
    // spurious mem_data_valid with no owner in flight
    inj = 1;
    settle();
    chk("err_memvalid_seen", {31'b0, bus.mem_data_valid}, 1);
    chk("err_no_valid", {30'b0, bus.icache_data_valid, bus.dcache_data_valid}, 0);
    tick();
    inj = 0;
    repeat (2) tick();
    // reset pulsed mid D fill: in-flight returns produce no valid, arbiter is idle afterwards
    for (int c = 0; c < 14; c++) begin
      tick();
      bus.dcache_fill_req = c < 3; bus.dcache_addr = 16'h7000 + 16'(2 * c);
      if (c < 3) rd(bus.dcache_addr);
      if (c == 3) rst = 0;
      if (c == 4) rst = 1;
      bus.icache_fill_req = c == 7 || c == 8; bus.icache_addr = 16'h7100 + 16'(2 * (c - 7));
      if (c == 7 || c == 8) rd(bus.icache_addr);
      settle();
      if (c == 3) chk("mrst_no_issue", {31'b0, bus.mem_enable}, 0);
      if (c >= 4 && c <= 6)
        chk("mrst_no_valid", {29'b0, bus.mem_data_valid, bus.icache_data_valid, bus.dcache_data_valid}, 4);
      if (c == 7) chk("mrst_idle_grant", {30'b0, bus.mem_enable, bus.icache_wait}, 2);
    end
    quiet();
    repeat (6) tick();
    chk("mem_queue_empty", exp_mem.size(), 0);
    chk("ret_queue_empty", exp_ret.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
